matrix_scan_driver: RTL

Parametrised scan driver for a shift-register LED matrix (e.g. the Pmod Matrix256). It holds a double-buffered, writable greyscale frame buffer of ROWS×COLS pixels at BPP bits each. It time-multiplexes the buffer into serial anode/cathode words for a 74HC595-style chain, driving serial_clk/serial_data/rclk/clear. Application logic such as the game engine writes the back bank and requests a swap, which takes effect only at a frame boundary so frames never tear.

---
 rtl/matrix_scan_driver.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/matrix_scan_driver.sv
// Scan driver for a 74HC595-chained LED matrix: double-buffered greyscale frame buffer,
// time-multiplexed into serial anode/cathode words with tear-free bank swaps.
module matrix_scan_driver #(
  parameter int unsigned ROWS = 16,
  parameter int unsigned COLS = 16,
  parameter int unsigned BPP  = 2,
  parameter int unsigned DIV  = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [$clog2(COLS)-1:0] wr_col,
  input  logic [BPP-1:0]          wr_data,
  input  logic                    swap_req,
  output logic                    swap_ack,
  output logic                    frame_start,
  output logic                    serial_clk,
  output logic                    serial_data,
  output logic                    rclk,
  output logic                    clear
);

  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned ColW = $clog2(COLS);
  localparam int unsigned N    = COLS + ROWS;
  localparam int unsigned BitW = $clog2(N);
  localparam int unsigned Subf = (1 << BPP) - 1;
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(N - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(ROWS - 1);
  localparam logic [BPP-1:0]  SubLast = BPP'(Subf - 1);

  logic [BPP-1:0] mem_q [2][ROWS][COLS];

  logic [DivW-1:0] div_q, div_d;
  logic            phase_q, phase_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [RowW-1:0] row_q, row_d;
  logic [BPP-1:0]  sub_q, sub_d;
  logic            started_q;
  logic            pending_q;
  logic            bank_sel_q;
  logic            sclk_q, sdata_q, rclk_q, clear_q, frame_start_q, swap_ack_q;

  logic            tick, even_tick, frame_tick, commit;
  logic            front_sel, write_bank;
  logic            is_anode, bit_val;
  logic [ColW-1:0] col_idx;
  logic [BPP-1:0]  pix;
  logic            row_ok, col_ok;

  assign tick       = (div_q == DivLast);
  assign even_tick  = tick && !phase_q;
  assign frame_tick = even_tick && (bit_q == '0) && (row_q == '0) && (sub_q == '0);
  assign commit     = frame_tick && pending_q;

  // Word 0 of a committing frame must already come from the new front bank.
  assign front_sel  = bank_sel_q ^ commit;
  assign write_bank = ~bank_sel_q;

  assign is_anode = (32'(bit_q) < COLS);
  assign col_idx  = is_anode ? ColW'(bit_q) : '0;
  assign pix      = mem_q[front_sel][row_q][col_idx];
  assign bit_val  = is_anode ? (pix > sub_q) : (32'(bit_q) != 32'(row_q) + COLS);

  assign row_ok = (32'(wr_row) < ROWS);
  assign col_ok = (32'(wr_col) < COLS);

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    row_d   = row_q;
    sub_d   = sub_q;
    if (tick) begin
      div_d   = '0;
      phase_d = ~phase_q;
      // Position advances after the rising-edge tick of each bit.
      if (phase_q) begin
        if (bit_q == BitLast) begin
          bit_d = '0;
          if (row_q == RowLast) begin
            row_d = '0;
            sub_d = (sub_q == SubLast) ? '0 : sub_q + 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    clear_q <= ~rst;
    if (rst) begin
      div_q         <= '0;
      phase_q       <= 1'b0;
      bit_q         <= '0;
      row_q         <= '0;
      sub_q         <= '0;
      started_q     <= 1'b0;
      pending_q     <= 1'b0;
      bank_sel_q    <= 1'b0;
      sclk_q        <= 1'b0;
      sdata_q       <= 1'b0;
      rclk_q        <= 1'b0;
      frame_start_q <= 1'b0;
      swap_ack_q    <= 1'b0;
    end else begin
      div_q         <= div_d;
      phase_q       <= phase_d;
      bit_q         <= bit_d;
      row_q         <= row_d;
      sub_q         <= sub_d;
      frame_start_q <= frame_tick;
      swap_ack_q    <= commit;
      if (tick) begin
        if (!phase_q) begin
          sclk_q    <= 1'b0;
          sdata_q   <= bit_val;
          // Latch the previous word while bit 0 of the next one shifts.
          rclk_q    <= (bit_q == '0) && started_q;
          started_q <= 1'b1;
        end else begin
          sclk_q <= 1'b1;
        end
      end
      if (commit) begin
        pending_q  <= swap_req;
        bank_sel_q <= ~bank_sel_q;
      end else if (swap_req) begin
        pending_q <= 1'b1;
      end
    end
  end

  // Frame buffer is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && row_ok && col_ok) begin
      mem_q[write_bank][wr_row][wr_col] <= wr_data;
    end
  end

  assign serial_clk  = sclk_q;
  assign serial_data = sdata_q;
  assign rclk        = rclk_q;
  assign clear       = clear_q;
  assign frame_start = frame_start_q;
  assign swap_ack    = swap_ack_q;

endmodule
